// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Provides XLEN, the NOP encoding, the PC alignment mask and the FIFO entry type.
package riscv_fetch_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] INST_NOP = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch_entry_t with flush (flush beats push).
// Ports: clk, rst_n, push/push_data, pop, flush, count, head (registered head entry).
module fetch_fifo
    import riscv_fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  fetch_entry_t  push_data,
    input  logic          pop,
    input  logic          flush,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: issues word-aligned PCs to a 1-cycle ROM and queues {pc, inst}.
// Ports: clk, rst_n, redirect*, mem* (ROM side), inst* (valid/ready to decode).
module instruction_fetch
    import riscv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirectValid,
    input  logic [XLEN-1:0] redirectPc,
    output logic            memEnable,
    output logic [XLEN-1:0] memAddress,
    input  logic [XLEN-1:0] memDataIn,
    output logic            instValid,
    output logic [XLEN-1:0] instData,
    output logic [XLEN-1:0] instPc,
    input  logic            instReady
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] inflight_pc;
    logic            inflight;
    logic [CW-1:0]   count;
    logic [CW:0]     occupied;
    logic            issue;
    logic            push;
    logic            pop;
    fetch_entry_t    push_data;
    fetch_entry_t    head;

    // Credit check counts the outstanding ROM read so a push never
    // lands on a full FIFO; a pop this cycle is deliberately not credited.
    assign occupied  = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign issue     = rst_n && !redirectValid && (occupied < DEPTH_W);
    assign memEnable = issue;
    assign memAddress = fetch_pc;

    // ROM output is registered every cycle, so only inflight qualifies it.
    assign push = inflight && !redirectValid;
    assign push_data = '{pc: inflight_pc, inst: memDataIn};
    assign pop = instValid && instReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc    <= RESET_PC & PC_ALIGN_MASK;
            inflight_pc <= '0;
            inflight    <= 1'b0;
        end else if (redirectValid) begin
            fetch_pc <= redirectPc & PC_ALIGN_MASK;
            inflight <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_pc <= fetch_pc;
                fetch_pc    <= fetch_pc + 32'd4;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redirectValid),
        .count     (count),
        .head      (head)
    );

    assign instValid = (count != '0);
    assign instData  = head.inst;
    assign instPc    = head.pc;

endmodule
